dmem_responder: RTL and testbench

- Data-memory responder that services the `mem_read`/`mem_write` strobes issued by the core's control unit.
- Holds a word-organised 16-bit data store.
- Inserts a configurable number of wait states per access and holds the pipeline via `stall_o`.
- Returns registered read data with a one-cycle valid pulse.
- Sits between the MEM stage and the write-back mux (`WB_MEM` source).

---
 rtl/dmem_responder.sv | 187 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the MEM stage. It holds a word-organised store of
// DEPTH 16-bit words, inserts WAIT_CYCLES wait states per access, holds the
// pipeline through stall_o, and returns registered read data with a one-cycle
// rvalid_o pulse. Its output feeds the write-back mux (WB_MEM source).
//
// Handshake: a request is mem_read_i | mem_write_i. While stall_o is high the
// requester keeps addr_i/wdata_i/strobes stable. The access completes in the
// first cycle with stall_o low (the DONE cycle). In that cycle rvalid_o pulses
// for loads only. The requester may present its next request in the cycle
// after DONE.
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   defined   : an odd addr_i is accepted, skips the wait states, touches no
//               storage and pulses err_o in its DONE cycle.
//   undefined : err_o is constant 0 and addr_i[0] is ignored.
//
// Parameters:
//   DEPTH       number of 16-bit words (power of two, 2..65536)
//   WAIT_CYCLES wait states before completion (0..15)
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   mem_read_i   load request
//   mem_write_i  store request (wins when both strobes are high)
//   addr_i       byte address; word index is addr_i[log2(DEPTH):1]
//   wdata_i      store data
//   rdata_o      registered load data, held until the next completed load
//   rvalid_o     one-cycle pulse marking rdata_o as valid for a completed load
//   stall_o      high while a request is pending
//   err_o        misaligned-access pulse (feature build only)
//   dbg_state_o  current FSM state (0 IDLE, 1 WAIT, 2 DONE)
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [15:0] addr_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] rdata_o,
    output logic        rvalid_o,
    output logic        stall_o,
    output logic        err_o,
    output logic [1:0]  dbg_state_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [AW-1:0]   cap_idx;
    logic [15:0]     cap_wdata;
    logic            cap_write;
    logic            cap_read;
    logic            cap_misalign;

    logic [15:0]     mem [DEPTH];

    // Zero-extend so DEPTH=65536 can still slice [AW:1] without leaving the bus.
    logic [16:0]     addr_ext;
    logic [AW-1:0]   in_idx;
    logic            in_misalign;
    logic            req;

    logic [AW-1:0]   cur_idx;
    logic [15:0]     cur_wdata;
    logic            cur_write;
    logic            cur_read;
    logic            cur_misalign;
    logic            to_done;
    logic            mem_we;
    logic            mem_re;
    logic            unused_addr;

    assign addr_ext    = {1'b0, addr_i};
    assign in_idx      = addr_ext[AW:1];
    assign req         = mem_read_i | mem_write_i;
    assign unused_addr = ^addr_ext;

`ifdef DMEM_ALIGN_CHECK_EN
    assign in_misalign = addr_i[0];
`else
    assign in_misalign = 1'b0;
`endif

    // The access that completes this cycle: the live inputs when completing
    // straight out of IDLE, otherwise the values captured at accept time.
    always_comb begin
        cur_idx      = cap_idx;
        cur_wdata    = cap_wdata;
        cur_write    = cap_write;
        cur_read     = cap_read;
        cur_misalign = cap_misalign;
        if (state == ST_IDLE) begin
            cur_idx      = in_idx;
            cur_wdata    = wdata_i;
            cur_write    = mem_write_i;
            cur_read     = mem_read_i & ~mem_write_i;
            cur_misalign = in_misalign;
        end
    end

    // Gating with rst_i drops any commit while reset is held.
    assign to_done = ~rst_i &
                     (((state == ST_IDLE) & req & (NO_WAIT | in_misalign)) |
                      ((state == ST_WAIT) & (cnt == 4'd0)));
    assign mem_we  = to_done & cur_write & ~cur_misalign;
    assign mem_re  = to_done & cur_read  & ~cur_misalign;

    // The reset gate keeps stall_o at 0 during reset even if a strobe is held.
    assign stall_o     = ~rst_i & (((state == ST_IDLE) & req) | (state == ST_WAIT));
    assign dbg_state_o = state;

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            rdata_o      <= 16'h0000;
            rvalid_o     <= 1'b0;
            err_o        <= 1'b0;
            cap_idx      <= '0;
            cap_wdata    <= 16'h0000;
            cap_write    <= 1'b0;
            cap_read     <= 1'b0;
            cap_misalign <= 1'b0;
        end else begin
            rvalid_o <= mem_re;
            err_o    <= to_done & cur_misalign;
            if (mem_re) begin
                rdata_o <= mem[cur_idx];
            end
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        cap_idx      <= in_idx;
                        cap_wdata    <= wdata_i;
                        cap_write    <= mem_write_i;
                        cap_read     <= mem_read_i & ~mem_write_i;
                        cap_misalign <= in_misalign;
                        if (to_done) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Two instances: dut_a (DEPTH=256, WAIT_CYCLES=2) and dut_b (WAIT_CYCLES=0).
// dut_a is followed by a behavioural model. Each access has the timeline
// "accept in cycle 0, complete in cycle WAITS+1". The model holds the word
// store as a plain array indexed by (addr/2) mod DEPTH. One compare process
// checks all dut_a outputs on every negedge. Literal expectations pin the
// model on key loads. dut_b gets directed per-cycle literal checks.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int WAITS = 2;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- dut_a ----------------
    logic        a_rd = 1'b0, a_wr = 1'b0;
    logic [15:0] a_addr = 16'h0, a_wdata = 16'h0;
    logic [15:0] a_rdata;
    logic        a_rvalid, a_stall, a_err;
    logic [1:0]  a_dbg;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITS)) dut_a (
        .clk_i(clk), .rst_i(rst), .mem_read_i(a_rd), .mem_write_i(a_wr),
        .addr_i(a_addr), .wdata_i(a_wdata), .rdata_o(a_rdata),
        .rvalid_o(a_rvalid), .stall_o(a_stall), .err_o(a_err),
        .dbg_state_o(a_dbg)
    );

    // ---------------- dut_b ----------------
    logic        b_rd = 1'b0, b_wr = 1'b0;
    logic [15:0] b_addr = 16'h0, b_wdata = 16'h0;
    logic [15:0] b_rdata;
    logic        b_rvalid, b_stall, b_err;
    logic [1:0]  b_dbg;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .mem_read_i(b_rd), .mem_write_i(b_wr),
        .addr_i(b_addr), .wdata_i(b_wdata), .rdata_o(b_rdata),
        .rvalid_o(b_rvalid), .stall_o(b_stall), .err_o(b_err),
        .dbg_state_o(b_dbg)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of dut_a ----------------
    logic [15:0] model_mem [DEPTH];
    logic [15:0] model_rdata = 16'h0000;
    logic        exp_stall = 1'b0, exp_rvalid = 1'b0, exp_err = 1'b0;
    logic [15:0] exp_rdata = 16'h0000;
    logic        cmp_en = 1'b0;

    function automatic int widx(input logic [15:0] addr);
        return (int'(addr) / 2) % DEPTH;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("a_stall",  {15'h0, a_stall},  {15'h0, exp_stall});
            check("a_rvalid", {15'h0, a_rvalid}, {15'h0, exp_rvalid});
            check("a_err",    {15'h0, a_err},    {15'h0, exp_err});
            check("a_rdata",  a_rdata,           exp_rdata);
        end
    end

    // Called just after a posedge; returns just after the posedge ending DONE.
    task automatic acc_a(input bit rd, input bit wr, input logic [15:0] addr, input logic [15:0] wd);
        bit is_rd;
        is_rd   = rd && !wr;
        a_rd    = rd;
        a_wr    = wr;
        a_addr  = addr;
        a_wdata = wd;
        for (int k = 0; k <= WAITS + 1; k++) begin
            if (k == WAITS + 1) begin
                if (wr) model_mem[widx(addr)] = wd;
                else if (is_rd) model_rdata = model_mem[widx(addr)];
            end
            exp_stall  = (k <= WAITS);
            exp_rvalid = is_rd && (k == WAITS + 1);
            exp_err    = 1'b0;
            exp_rdata  = model_rdata;
            @(posedge clk);
            #1;
        end
        a_rd       = 1'b0;
        a_wr       = 1'b0;
        exp_stall  = 1'b0;
        exp_rvalid = 1'b0;
    endtask

    task automatic load_lit_a(input logic [15:0] addr, input logic [15:0] lit, input string name);
        acc_a(1'b1, 1'b0, addr, 16'h0000);
        check({name, "_dut"},   a_rdata,     lit);
        check({name, "_model"}, model_rdata, lit);
    endtask

    // dut_b access with literal expectations for the accept and DONE cycles.
    task automatic acc_b(input bit rd, input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                         input bit e_err, input bit e_rvalid, input logic [15:0] e_rdata,
                         input string name);
        b_rd    = rd;
        b_wr    = wr;
        b_addr  = addr;
        b_wdata = wd;
        @(negedge clk);
        check({name, "_acc_stall"},  {15'h0, b_stall},  16'h0001);
        check({name, "_acc_rvalid"}, {15'h0, b_rvalid}, 16'h0000);
        @(posedge clk);
        #1;
        @(negedge clk);
        check({name, "_done_stall"},  {15'h0, b_stall},  16'h0000);
        check({name, "_done_rvalid"}, {15'h0, b_rvalid}, {15'h0, e_rvalid});
        check({name, "_done_err"},    {15'h0, b_err},    {15'h0, e_err});
        check({name, "_done_rdata"},  b_rdata,           e_rdata);
        @(posedge clk);
        #1;
        b_rd = 1'b0;
        b_wr = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        cmp_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // store then load, same word
        acc_a(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        load_lit_a(16'h0010, 16'hBEEF, "raw_0010");

        // both strobes: write wins, no rvalid
        acc_a(1'b1, 1'b1, 16'h0020, 16'h1234);
        load_lit_a(16'h0020, 16'h1234, "both_0020");

        // address wrap at 2*DEPTH bytes
        acc_a(1'b0, 1'b1, 16'h0200, 16'hA5A5);
        load_lit_a(16'h0000, 16'hA5A5, "wrap_0000");

        // last word reached through an upper-bit alias
        acc_a(1'b0, 1'b1, 16'h01FE, 16'h0F0F);
        load_lit_a(16'hFFFE, 16'h0F0F, "top_fffe");
        load_lit_a(16'h0010, 16'hBEEF, "reread_0010");

        // reset in the middle of a store
        acc_a(1'b0, 1'b1, 16'h0030, 16'h1111);
        cmp_en  = 1'b0;
        a_wr    = 1'b1;
        a_addr  = 16'h0030;
        a_wdata = 16'h5555;
        @(posedge clk);
        #1;
        check("pre_rst_stall", {15'h0, a_stall}, 16'h0001);
        #2;
        rst = 1'b1;
        #1;
        check("rst_stall",  {15'h0, a_stall},  16'h0000);
        check("rst_rvalid", {15'h0, a_rvalid}, 16'h0000);
        check("rst_err",    {15'h0, a_err},    16'h0000);
        check("rst_rdata",  a_rdata,           16'h0000);
        @(posedge clk);
        #1;
        a_wr = 1'b0;
        check("rst_hold_rdata", a_rdata, 16'h0000);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_rdata = 16'h0000;
        exp_rdata   = 16'h0000;
        cmp_en      = 1'b1;
        load_lit_a(16'h0030, 16'h1111, "rst_drop_0030");

        // zero-wait instance, odd address handling
        acc_b(1'b0, 1'b1, 16'h0010, 16'h2222, 1'b0, 1'b0, 16'h0000, "b_st_0010");
        acc_b(1'b0, 1'b1, 16'h0011, 16'h7777, ALIGN, 1'b0, 16'h0000, "b_st_0011");
        acc_b(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1,
              ALIGN ? 16'h2222 : 16'h7777, "b_ld_0010");

        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
